// File: rtl/mux4_arb_pkg.sv
// Shared types, sizes and helpers for the 4-way round-robin packet arbiter.
package mux4_arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    // Result of one round-robin arbitration.
    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // Requester index to mux select (inverted encoding). The mapping is its
    // own inverse, so it also recovers the index from a select value.
    function automatic logic [IDX_W-1:0] idx2sel(input logic [IDX_W-1:0] idx);
        return ~idx;
    endfunction

    // First set request scanning ptr+1, ptr+2, ptr+3, ptr (mod N_REQ).
    function automatic rr_pick_t rr_pick(input logic [N_REQ-1:0] req,
                                         input logic [IDX_W-1:0] ptr);
        rr_pick_t         r;
        logic [IDX_W-1:0] c;
        r = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            c = ptr + IDX_W'(k);
            if (!r.vld && req[c]) begin
                r.vld = 1'b1;
                r.idx = c;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux4_dw.sv
// DW-bit 4:1 select datapath using the inverted select encoding
// (11 -> d0, 10 -> d1, 01 -> d2, 00 -> d3).
module mux4_dw #(
    parameter int unsigned DW = 2
) (
    input  logic [1:0]    sel,
    input  logic [DW-1:0] d0,
    input  logic [DW-1:0] d1,
    input  logic [DW-1:0] d2,
    input  logic [DW-1:0] d3,
    output logic [DW-1:0] y
);

    // Pure combinational lane select.
    always_comb begin
        y = '0;
        case (sel)
            2'b11:   y = d0;
            2'b10:   y = d1;
            2'b01:   y = d2;
            2'b00:   y = d3;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin packet arbiter sharing one 4:1 datapath among four
// valid/ready requesters; grant is held until the granted packet's last beat.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int unsigned DW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] in_valid,
    input  logic [N_REQ-1:0] in_last,
    input  logic [DW-1:0]    d0,
    input  logic [DW-1:0]    d1,
    input  logic [DW-1:0]    d2,
    input  logic [DW-1:0]    d3,
    output logic [N_REQ-1:0] in_ready,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic [1:0]       sel,
    output logic [N_REQ-1:0] grant
);

    state_e           state_q;
    logic [N_REQ-1:0] grant_q;
    logic [IDX_W-1:0] sel_q;
    logic [IDX_W-1:0] ptr_q;

    logic [IDX_W-1:0] gidx;
    rr_pick_t         pick;
    logic             lock;
    logic             cur_valid;
    logic             cur_last;
    logic             xfer;
    logic [DW-1:0]    mux_y;

    // Shared data lane select driven by the registered select.
    mux4_dw #(.DW(DW)) u_mux (
        .sel (sel_q),
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .y   (mux_y)
    );

    // Handshake steering derived from the registered grant/select; no data registers.
    always_comb begin
        gidx      = idx2sel(sel_q);
        pick      = rr_pick(in_valid, ptr_q);
        lock      = (state_q == LOCK);
        cur_valid = in_valid[gidx];
        cur_last  = in_last[gidx];
        xfer      = lock && cur_valid && out_ready;
        out_valid = lock && cur_valid;
        out_last  = lock && cur_valid && cur_last;
        out_data  = lock ? mux_y : '0;
        in_ready  = (lock && out_ready) ? grant_q : '0;
    end

    // Arbitration FSM: arbitrate in IDLE, hold the grant in LOCK until the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= 2'b11;
            ptr_q   <= 2'd3;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick.vld) begin
                        grant_q <= N_REQ'(1) << pick.idx;
                        sel_q   <= idx2sel(pick.idx);
                        state_q <= LOCK;
                    end
                end
                LOCK: begin
                    if (xfer && cur_last) begin
                        ptr_q   <= gidx;
                        grant_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;

    // Structural invariants of the grant/select/ready relationship.
    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant_q));
    a_sel_matches: assert property (@(posedge clk) disable iff (!rst_n)
        (grant_q != '0) |-> (grant_q == (N_REQ'(1) << idx2sel(sel_q))));
    a_ready_subset: assert property (@(posedge clk) disable iff (!rst_n)
        ((in_ready & ~grant_q) == '0));
    a_no_idle_xfer: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == IDLE) |-> (in_ready == '0));

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin packet arbiter that shares one 4:1, DW-bit select datapath between four valid/ready requesters.
- Grants one requester at a time and holds the grant until that requester's last beat is accepted downstream.
- Drives the shared mux select with the block's fixed encoding: sel 11 selects d0, 10 selects d1, 01 selects d2, 00 selects d3.
- Sits between four packet sources and a single downstream consumer.

Parameters:
DW, 2, data width of each requester lane and of the output.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  4  per-requester valid; bit i belongs to requester i.
in_last  input  4  per-requester last-beat flag, qualified by in_valid.
d0, d1, d2, d3  input  DW each  requester data lanes.
in_ready  output  4  per-requester ready.
out_valid  output  1  downstream valid.
out_data  output  DW  muxed data.
out_last  output  1  muxed last flag.
out_ready  input  1  downstream ready.
sel  output  2  registered mux select, using the encoding above.
grant  output  4  one-hot registered grant; all zero when idle.

Behaviour:
- Reset: the async assert of rst_n forces the following:
  - state IDLE, grant 0000, sel 11, round-robin pointer ptr = 3 (requester 0 has highest priority first).
  - in_ready 0000, out_valid 0, out_last 0, out_data 0.
- States: IDLE and LOCK.
- IDLE:
  - out_valid = 0, in_ready = 0000.
  - If any in_valid bit is set, pick the first set bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Register grant = onehot(winner) and sel = ~winner[1:0]; go to LOCK.
  - Arbitration latency is one cycle: the first beat can transfer no earlier than the cycle after the request is seen.
- LOCK, with granted index g:
  - out_valid = in_valid[g].
  - out_data = the lane chosen by sel; out_last = in_last[g] & in_valid[g].
  - in_ready[g] = out_ready; all other in_ready bits = 0.
  - These outputs are combinational from the registered sel/grant; there are no data registers.
- Handshake: a transfer occurs when in_valid[g] & out_ready.
  - A transfer with in_last[g] = 1 ends the burst: ptr <= g, grant <= 0000, go to IDLE.
  - sel holds its last value in IDLE.
  - Minimum one bubble cycle between bursts.
- Fairness: a requester just served is lowest priority on the next arbitration. With all four continuously requesting, the order is 0, 1, 2, 3, 0, ...
- Grant stability:
  - Grant never changes in LOCK, even if in_valid[g] drops mid-burst. Gaps are allowed; out_valid follows in_valid[g].
  - Other requesters' valid bits have no effect in LOCK.
- Single-beat burst: last on the first beat is legal. LOCK lasts exactly one cycle if out_ready = 1.
- Simultaneous new requests while the last beat transfers are not seen until the IDLE cycle; no same-cycle re-grant.
- Reset mid-burst: the burst is abandoned immediately. The partial packet is lost; there is no recovery.
- Protocol: requesters must hold data and last stable while valid && !ready. Out_valid/out_data obey the same rule as long as the sources do.
- Invariants to assert:
  - grant is one-hot or zero.
  - sel == ~index(grant) whenever grant != 0.
  - in_ready is a subset of grant.
  - No transfer occurs in IDLE.

Decomposition:
- Package mux4_arb_pkg contains:
  - state enum {IDLE, LOCK}.
  - localparam N_REQ = 4.
  - function idx2sel (index to the inverted select encoding).
  - function rr_pick(req[3:0], ptr[1:0]) returning a valid flag and a 2-bit index.
- One natural sub-module, mux4_dw: the parameterised DW-bit 4:1 select datapath using the same sel encoding. The arbiter instantiates it for out_data; out_last uses in_last[g] directly.

Test Plan:
- Reset with all in_valid = 1111 held. After rst_n release: cycle 1 grant = 0001, sel = 11; cycle 2 out_valid = 1 and out_data = d0.
- Requesters 0–3 each send 2-beat bursts continuously, out_ready = 1. Grant order is 0001, 0010, 0100, 1000, 0001, with one idle cycle between bursts. sel sequence is 11, 10, 01, 00.
- Requester 2 alone sends 3 beats (d2 = 01, 10, 11) with out_ready toggling 1, 0, 1, 1. Required response:
  - out_data/out_valid are held during the stall.
  - Exactly 3 transfers occur; in_ready = 0100 only when out_ready = 1.
  - Grant returns to 0000 after the last beat.
- In LOCK on requester 1, requester 1 drops valid for 2 cycles and requester 3 requests. Grant stays 0010 and out_valid = 0 during the gap. Requester 3 is granted only after requester 1's last beat.
- rst_n is pulsed low asynchronously mid-burst on requester 3. Outputs drop to reset values in the same cycle without waiting for a clock edge. After release, requester 0 wins if all are requesting.
- Single-beat packets (last = 1) from requesters 1 and 2 arrive simultaneously while ptr = 1. Requester 2 is served first, then requester 1. Each LOCK lasts exactly one cycle.
